// File: rtl/future_mix_sched_pkg.sv
// Shared constants, FSM state type and column-slice helper for the FUTURE
// column-mix sequencer.
package future_pkg;

    localparam int COL_W   = 16;
    localparam int NCOL    = 4;
    localparam int STATE_W = COL_W * NCOL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Column k of a 64-bit state; column k occupies bits [16k+15:16k].
    function automatic logic [COL_W-1:0] col_slice(input logic [STATE_W-1:0] state,
                                                   input logic [1:0]         k);
        return state[k*COL_W +: COL_W];
    endfunction

endpackage

// File: rtl/future_mix_sched_colmix.sv
// 16-bit FUTURE column-mix datapath: purely combinational, GF(2)-linear,
// c = b ^ rotl(b,3) ^ rotl(b,9), so an all-zero column mixes to all-zero.
module future_mix_sched_colmix
    import future_pkg::*;
(
    input  logic [COL_W-1:0] b_i,
    output logic [COL_W-1:0] c_o
);

    assign c_o = b_i ^ {b_i[12:0], b_i[15:13]} ^ {b_i[6:0], b_i[15:7]};

endmodule

// File: rtl/future_mix_sched.sv
// Feeds the four columns of a round state one per cycle through a single
// column mixer. Optional final-round bypass: FUTURE_MIX_LAST_SKIP_EN.
module future_mix_sched
    import future_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy,
    output logic [1:0]         col_idx
);

    fsm_state_e         state_q, state_d;
    logic [STATE_W-1:0] src_q, src_d;
    logic [STATE_W-1:0] res_q, res_d;
    logic [1:0]         col_q, col_d;
    logic               rdy_q, rdy_d;
    logic               accept_s;
    logic               skip_s;
    logic [COL_W-1:0]   mix_in_s;
    logic [COL_W-1:0]   mix_out_s;

    assign accept_s = rdy_q & in_valid;

`ifdef FUTURE_MIX_LAST_SKIP_EN
    assign skip_s = in_last;
`else
    logic unused_last_s;
    assign unused_last_s = in_last;
    assign skip_s        = 1'b0;
`endif

    assign mix_in_s = col_slice(src_q, col_q);

    future_mix_sched_colmix u_colmix (
        .b_i (mix_in_s),
        .c_o (mix_out_s)
    );

    // Next-state, source/result capture and column counter.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        res_d   = res_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    src_d = in_state;
                    col_d = 2'd0;
                    if (skip_s) begin
                        res_d   = in_state;
                        state_d = DONE;
                    end else begin
                        state_d = MIX;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MIX: begin
                res_d[col_q*COL_W +: COL_W] = mix_out_s;
                col_d = col_q + 2'd1;
                if (col_q == 2'(NCOL - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = MIX;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                col_d   = 2'd0;
            end
        endcase
        // Ready is registered so it stays low throughout reset and rises one cycle later.
        rdy_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= 64'h0;
            res_q   <= 64'h0;
            col_q   <= 2'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            res_q   <= res_d;
            col_q   <= col_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MIX);
    assign out_state = res_q;
    assign col_idx   = col_q;

endmodule

// File: tb/tb_future_mix_sched.sv
// Scoreboard bench for future_mix_sched; expectations come from an
// independent bit-level model of the column mix.
module tb_future_mix_sched;

`ifdef FUTURE_MIX_LAST_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_state;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_state;
    logic        busy;
    logic [1:0]  col_idx;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_out;

    always #5 clk = ~clk;

    future_mix_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy),
        .col_idx   (col_idx)
    );

    function automatic logic [15:0] mix_ref(input logic [15:0] b);
        logic [15:0] c;
        for (int j = 0; j < 16; j++) c[j] = b[j] ^ b[(j + 13) % 16] ^ b[(j + 7) % 16];
        return c;
    endfunction

    function automatic logic [63:0] state_ref(input logic [63:0] st, input logic last);
        logic [63:0] r;
        if (SKIP_EN && last) return st;
        for (int k = 0; k < 4; k++) r[16*k +: 16] = mix_ref(st[16*k +: 16]);
        return r;
    endfunction

    task automatic do_txn(input logic [63:0] st, input logic last, input int stall, input bit poke);
        int          cyc;
        int          nbusy;
        logic [1:0]  idx_exp;
        logic [63:0] held;
        logic [63:0] exp_v;
        bit          exp_skip;
        int          exp_lat;
        exp_skip  = SKIP_EN && last;
        exp_lat   = exp_skip ? 1 : 5;
        out_ready = (stall == 0);
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL in_ready_wait: got %b want 1", in_ready); end
        in_valid = 1'b1; in_state = st; in_last = last;
        exp_q.push_back(state_ref(st, last));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        cyc = 1; nbusy = 0; idx_exp = 2'd0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) begin
                n_cmp++;
                if (col_idx !== idx_exp) begin n_err++; $display("FAIL col_idx_seq: got %0d want %0d", col_idx, idx_exp); end
                idx_exp++; nbusy++;
            end
            @(negedge clk); cyc++;
        end
        n_cmp++;
        if (cyc != exp_lat) begin n_err++; $display("FAIL latency: got %0d want %0d", cyc, exp_lat); end
        n_cmp++;
        if (nbusy != (exp_skip ? 0 : 4)) begin n_err++; $display("FAIL busy_cycles: got %0d want %0d", nbusy, exp_skip ? 0 : 4); end
        held = out_state;
        for (int i = 0; i < stall; i++) begin
            if (poke) begin in_valid = 1'b1; in_state = {$urandom(), $urandom()}; end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || out_state !== held) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b r=%b b=%b st=%h want v=1 r=0 b=0 st=%h", out_valid, in_ready, busy, out_state, held);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        exp_v = exp_q.pop_front();
        last_out = out_state;
        n_cmp++;
        if (out_state !== exp_v) begin n_err++; $display("FAIL out_state: got %h want %h", out_state, exp_v); end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_state = 64'h0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_state !== 64'h0) begin n_err++; $display("FAIL rst_out_state: got %h want 0", out_state); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (col_idx !== 2'd0)    begin n_err++; $display("FAIL rst_col_idx: got %0d want 0", col_idx); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single;
        do_txn(64'h0000_0000_0000_0001, 1'b0, 0, 1'b0);
        n_cmp++; if (last_out[15:0] !== 16'h0209) begin n_err++; $display("FAIL single_col0: got %h want 0209", last_out[15:0]); end
        n_cmp++; if (last_out[63:16] !== 48'h0)   begin n_err++; $display("FAIL single_upper: got %h want 0", last_out[63:16]); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 200; t++)
            do_txn({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    endtask

    task automatic test_backpressure;
        do_txn({$urandom(), $urandom()}, 1'b0, 20, 1'b1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_no_launch: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_mix;
        int cyc;
        out_ready = 1'b1;
        in_valid = 1'b1; in_state = 64'hDEAD_BEEF_CAFE_F00D; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!(busy === 1'b1 && col_idx === 2'd2) && cyc < 10) begin @(negedge clk); cyc++; end
        n_cmp++; if (cyc >= 10) begin n_err++; $display("FAIL mid_mix_reach: got timeout want col_idx=2"); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_state !== 64'h0) begin n_err++; $display("FAIL mid_rst_out_state: got %h want 0", out_state); end
        n_cmp++; if (col_idx !== 2'd0)    begin n_err++; $display("FAIL mid_rst_col_idx: got %0d want 0", col_idx); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        do_txn(64'h1234_0000_FFFF_8001, 1'b0, 1, 1'b0);
    endtask

    task automatic test_last;
        do_txn(64'h0123_4567_89AB_CDEF, 1'b1, 0, 1'b0);
        if (SKIP_EN) begin
            n_cmp++;
            if (last_out !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL skip_passthru: got %h want 0123456789abcdef", last_out); end
        end else begin
            n_cmp++;
            if (last_out === 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL last_ignored: got unmixed %h", last_out); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_random();
        test_backpressure();
        test_reset_mid_mix();
        test_last();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
